// File: rtl/crtc_pkg.sv
// -----------------------------------------------------------------------------
// crtc_pkg -- shared definitions for the CRTC6845 video timing generator.
//   * register index constants R_HTOTAL .. R_CURLO
//   * register width constants W_* (bits actually stored per register)
//   * vertical state enum (V_NORMAL / V_ADJUST)
//   * reg_mask(): truncation mask applied to CPU writes of each register
// -----------------------------------------------------------------------------
package crtc_pkg;

  localparam int R_HTOTAL    = 0;
  localparam int R_HDISP     = 1;
  localparam int R_HSYNCPOS  = 2;
  localparam int R_SYNCW     = 3;
  localparam int R_VTOTAL    = 4;
  localparam int R_VADJUST   = 5;
  localparam int R_VDISP     = 6;
  localparam int R_VSYNCPOS  = 7;
  localparam int R_INTERLACE = 8;
  localparam int R_MAXRASTER = 9;
  localparam int R_CURSTART  = 10;
  localparam int R_CUREND    = 11;
  localparam int R_STARTHI   = 12;
  localparam int R_STARTLO   = 13;
  localparam int R_CURHI     = 14;
  localparam int R_CURLO     = 15;

  localparam int W_HTOTAL    = 8;
  localparam int W_HDISP     = 8;
  localparam int W_HSYNCPOS  = 8;
  localparam int W_SYNCW     = 8;
  localparam int W_VTOTAL    = 7;
  localparam int W_VADJUST   = 5;
  localparam int W_VDISP     = 7;
  localparam int W_VSYNCPOS  = 7;
  localparam int W_INTERLACE = 2;
  localparam int W_MAXRASTER = 5;
  localparam int W_CURSTART  = 7;
  localparam int W_CUREND    = 5;
  localparam int W_STARTHI   = 6;
  localparam int W_STARTLO   = 8;
  localparam int W_CURHI     = 6;
  localparam int W_CURLO     = 8;

  typedef enum logic {
    V_NORMAL = 1'b0,
    V_ADJUST = 1'b1
  } vstate_t;

  // Mask of the implemented bits of register idx; unimplemented bits read as 0.
  function automatic logic [7:0] reg_mask(input logic [3:0] idx);
    int w;
    case (int'(idx))
      R_HTOTAL:    w = W_HTOTAL;
      R_HDISP:     w = W_HDISP;
      R_HSYNCPOS:  w = W_HSYNCPOS;
      R_SYNCW:     w = W_SYNCW;
      R_VTOTAL:    w = W_VTOTAL;
      R_VADJUST:   w = W_VADJUST;
      R_VDISP:     w = W_VDISP;
      R_VSYNCPOS:  w = W_VSYNCPOS;
      R_INTERLACE: w = W_INTERLACE;
      R_MAXRASTER: w = W_MAXRASTER;
      R_CURSTART:  w = W_CURSTART;
      R_CUREND:    w = W_CUREND;
      R_STARTHI:   w = W_STARTHI;
      R_STARTLO:   w = W_STARTLO;
      R_CURHI:     w = W_CURHI;
      default:     w = W_CURLO;
    endcase
    return 8'((9'd1 << w) - 9'd1);
  endfunction

endpackage

// File: rtl/crtc_regfile.sv
// -----------------------------------------------------------------------------
// crtc_regfile -- CPU-visible address register, R0..R15 storage and read mux.
// Ports:
//   ck16, reset          clock / synchronous active-high reset
//   bus_we, bus_rs, din  CPU write strobe, register select (0=addr,1=data), data
//   dout                 read data: R14/R15 only, 0x00 otherwise (combinational)
//   htotal..start_lo     register values consumed by the timing logic
// R8, R10, R11, R14, R15 are stored but only R14/R15 are observable (via dout).
// -----------------------------------------------------------------------------
module crtc_regfile
  import crtc_pkg::*;
(
  input  logic       ck16,
  input  logic       reset,
  input  logic       bus_we,
  input  logic       bus_rs,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [7:0] htotal,
  output logic [7:0] hdisp,
  output logic [7:0] hsyncpos,
  output logic [7:0] syncw,
  output logic [6:0] vtotal,
  output logic [4:0] vadjust,
  output logic [6:0] vdisp,
  output logic [6:0] vsyncpos,
  output logic [4:0] maxraster,
  output logic [5:0] start_hi,
  output logic [7:0] start_lo
);

  logic [4:0] addr_q;
  logic [7:0] regs_q [16];

  always_ff @(posedge ck16) begin
    if (reset) begin
      addr_q <= 5'd0;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (bus_we) begin
      if (!bus_rs) begin
        addr_q <= din[4:0];
      end else if (!addr_q[4]) begin
        // Addresses 16..31 fall through and change nothing.
        regs_q[addr_q[3:0]] <= din & reg_mask(addr_q[3:0]);
      end
    end
  end

  always_comb begin
    dout = 8'h00;
    if (bus_rs) begin
      if (addr_q == 5'd14) begin
        dout = regs_q[R_CURHI];
      end else if (addr_q == 5'd15) begin
        dout = regs_q[R_CURLO];
      end
    end
  end

  assign htotal    = regs_q[R_HTOTAL];
  assign hdisp     = regs_q[R_HDISP];
  assign hsyncpos  = regs_q[R_HSYNCPOS];
  assign syncw     = regs_q[R_SYNCW];
  assign vtotal    = regs_q[R_VTOTAL][6:0];
  assign vadjust   = regs_q[R_VADJUST][4:0];
  assign vdisp     = regs_q[R_VDISP][6:0];
  assign vsyncpos  = regs_q[R_VSYNCPOS][6:0];
  assign maxraster = regs_q[R_MAXRASTER][4:0];
  assign start_hi  = regs_q[R_STARTHI][5:0];
  assign start_lo  = regs_q[R_STARTLO];

endmodule

// File: rtl/crtc6845.sv
// -----------------------------------------------------------------------------
// crtc6845 -- CRT controller timing core (6845-style).
// Ports:
//   ck16, reset   single clock / synchronous active-high reset
//   cen           character-clock enable; counters and outputs move only on it
//   bus_we, bus_rs, din, dout   CPU register interface (see crtc_regfile)
//   ma, ra        character memory address and raster line within the row
//   hsync, vsync, dispen        active-high video timing outputs
// All outputs are registered and computed from the next counter values, so
// they line up with the counter state they describe.
// -----------------------------------------------------------------------------
module crtc6845
  import crtc_pkg::*;
(
  input  logic        ck16,
  input  logic        reset,
  input  logic        cen,
  input  logic        bus_we,
  input  logic        bus_rs,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [13:0] ma,
  output logic [4:0]  ra,
  output logic        hsync,
  output logic        vsync,
  output logic        dispen
);

  logic [7:0] htotal, hdisp, hsyncpos, syncw, start_lo;
  logic [6:0] vtotal, vdisp, vsyncpos;
  logic [4:0] vadjust, maxraster;
  logic [5:0] start_hi;

  crtc_regfile u_regs (
    .ck16      (ck16),
    .reset     (reset),
    .bus_we    (bus_we),
    .bus_rs    (bus_rs),
    .din       (din),
    .dout      (dout),
    .htotal    (htotal),
    .hdisp     (hdisp),
    .hsyncpos  (hsyncpos),
    .syncw     (syncw),
    .vtotal    (vtotal),
    .vadjust   (vadjust),
    .vdisp     (vdisp),
    .vsyncpos  (vsyncpos),
    .maxraster (maxraster),
    .start_hi  (start_hi),
    .start_lo  (start_lo)
  );

  logic [7:0]  hcc_q, hcc_d;
  logic [6:0]  vcc_q, vcc_d;
  logic [4:0]  rc_q, rc_d;
  vstate_t     state_q, state_d;
  logic [13:0] row_start_q, row_start_d;
  logic [3:0]  hswc_q, hswc_d;
  logic [4:0]  vswc_q, vswc_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        dispen_q, dispen_d;
  logic [13:0] ma_q, ma_d;

  logic       eol;        // this cen ends the current line
  logic       new_frame;  // this end of line starts a new frame
  logic       row_wrap;   // this end of line takes rc back to 0
  logic [4:0] vs_len;     // vsync length in lines; 0 in R3[7:4] means 16

  always_comb begin
    hcc_d       = hcc_q;
    vcc_d       = vcc_q;
    rc_d        = rc_q;
    state_d     = state_q;
    row_start_d = row_start_q;
    hswc_d      = hswc_q;
    vswc_d      = vswc_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    dispen_d    = dispen_q;
    ma_d        = ma_q;
    new_frame   = 1'b0;
    row_wrap    = 1'b0;
    eol         = (hcc_q == htotal);
    vs_len      = (syncw[7:4] == 4'd0) ? 5'd16 : {1'b0, syncw[7:4]};

    if (cen) begin
      // A lowered R0 simply lets hcc run on through 255 back to 0.
      hcc_d = eol ? 8'd0 : hcc_q + 8'd1;

      if ((hcc_d == hsyncpos) && (syncw[3:0] != 4'd0)) begin
        hsync_d = 1'b1;
        hswc_d  = 4'd0;
      end else if (hsync_q) begin
        hswc_d = hswc_q + 4'd1;
        if (hswc_q + 4'd1 == syncw[3:0]) begin
          hsync_d = 1'b0;
        end
      end

      if (eol) begin
        case (state_q)
          V_NORMAL: begin
            if (rc_q != maxraster) begin
              rc_d = rc_q + 5'd1;
            end else begin
              row_wrap    = 1'b1;
              row_start_d = row_start_q + {6'd0, hdisp};
              if (vcc_q != vtotal) begin
                rc_d  = 5'd0;
                vcc_d = vcc_q + 7'd1;
              end else if (vadjust == 5'd0) begin
                new_frame = 1'b1;
              end else begin
                rc_d    = 5'd0;
                state_d = V_ADJUST;
              end
            end
          end
          default: begin
            if (rc_q == vadjust - 5'd1) begin
              new_frame = 1'b1;
              row_wrap  = 1'b1;
            end else begin
              rc_d = rc_q + 5'd1;
            end
          end
        endcase

        if (new_frame) begin
          vcc_d       = 7'd0;
          rc_d        = 5'd0;
          state_d     = V_NORMAL;
          row_start_d = {start_hi, start_lo};
        end

        if (row_wrap && (vcc_d == vsyncpos)) begin
          vsync_d = 1'b1;
          vswc_d  = 5'd0;
        end else if (vsync_q) begin
          vswc_d = vswc_q + 5'd1;
          if (vswc_q + 5'd1 == vs_len) begin
            vsync_d = 1'b0;
          end
        end
      end

      dispen_d = (hcc_d < hdisp) && (vcc_d < vdisp) && (state_d == V_NORMAL);
      ma_d     = row_start_d + {6'd0, hcc_d};
    end
  end

  always_ff @(posedge ck16) begin
    if (reset) begin
      hcc_q       <= 8'd0;
      vcc_q       <= 7'd0;
      rc_q        <= 5'd0;
      state_q     <= V_NORMAL;
      row_start_q <= 14'd0;
      hswc_q      <= 4'd0;
      vswc_q      <= 5'd0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      dispen_q    <= 1'b0;
      ma_q        <= 14'd0;
    end else begin
      hcc_q       <= hcc_d;
      vcc_q       <= vcc_d;
      rc_q        <= rc_d;
      state_q     <= state_d;
      row_start_q <= row_start_d;
      hswc_q      <= hswc_d;
      vswc_q      <= vswc_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      dispen_q    <= dispen_d;
      ma_q        <= ma_d;
    end
  end

  assign ma     = ma_q;
  assign ra     = rc_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign dispen = dispen_q;

endmodule

// File: doc/crtc6845.md
CRTC6845 -- requirements
Module: crtc6845

Interface
REQ-001 The block SHALL have no parameters; all timing comes from its registers.
REQ-002 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-003 ck16  in  1  system clock, the only clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cen  in  1  one-ck16-cycle character-clock enable (one per CCLK period).
REQ-006 bus_we  in  1  one-cycle CPU write strobe.
REQ-007 bus_rs  in  1  register select: 0 = address register, 1 = data register.
REQ-008 din  in  8  CPU write data.
REQ-009 dout  out  8  CPU read data, combinational from bus_rs and the address register.
REQ-010 ma  out  14  memory (character) address.
REQ-011 ra  out  5  raster address within the character row.
REQ-012 hsync  out  1  horizontal sync, active-high.
REQ-013 vsync  out  1  vertical sync, active-high.
REQ-014 dispen  out  1  display enable, active-high.

Function
REQ-015 Address register write SHALL occur when bus_we=1 and bus_rs=0; it SHALL latch din[4:0].
REQ-016 Data write SHALL occur when bus_we=1 and bus_rs=1; it SHALL load R[addr] for addr 0..15, truncated to each register's width; addresses 16..31 SHALL be ignored.
REQ-017 Register widths SHALL be:
- R0 htotal 8; R1 hdisp 8; R2 hsyncpos 8.
- R3 8, where [3:0] = hsync width and [7:4] = vsync width.
- R4 vtotal 7; R5 vadjust 5; R6 vdisp 7; R7 vsyncpos 7.
- R8 2; R9 maxraster 5; R10 7; R11 5; R12 6; R13 8; R14 6; R15 8.
- R8, R10, R11, R14 and R15 SHALL be storage only.
REQ-018 dout SHALL be:
- R14 zero-extended when bus_rs=1 and addr=14.
- R15 when bus_rs=1 and addr=15.
- 0x00 otherwise.
REQ-019 Counters and all video outputs SHALL change only on ck16 edges with cen=1; with cen=0 they SHALL hold.
REQ-020 Horizontal counter hcc (8-bit): on cen, if hcc==R0 it SHALL become 0 (end of line), else increment. If R0 is lowered below hcc, hcc SHALL wrap naturally through 255 to 0.
REQ-021 hsync:
- On a cen where the next hcc equals R2 and R3[3:0]!=0, hsync SHALL be set and the width counter cleared.
- The width counter SHALL increment each later cen; hsync SHALL clear when the counter reaches R3[3:0].
- R3[3:0]=0 SHALL produce no hsync.
REQ-022 The vertical state machine SHALL have two states, NORMAL and ADJUST. At each end of line:
- NORMAL, rc!=R9: rc SHALL increment.
- NORMAL, rc==R9, vcc!=R4: rc SHALL become 0 and vcc SHALL increment.
- NORMAL, rc==R9, vcc==R4: if R5==0, start a new frame; else rc SHALL become 0 and the state SHALL go to ADJUST.
- ADJUST: rc SHALL increment; when rc==R5-1, start a new frame.
- New frame: vcc=0, rc=0, state NORMAL.
REQ-023 vsync:
- At the end of line that enters rc=0 with the new vcc==R7, vsync SHALL be set and the line counter cleared.
- The line counter SHALL increment at each later end of line; vsync SHALL clear when it reaches R3[7:4]; a value of 0 SHALL mean 16 lines.
REQ-024 dispen SHALL equal (hcc<R1) AND (vcc<R6) AND (state==NORMAL), registered with the counters.
REQ-025 Addressing:
- ma SHALL equal row_start + hcc, modulo 2^14.
- At a new frame, row_start SHALL load {R12,R13}.
- At an end of line in NORMAL with rc==R9, row_start SHALL add R1.
- ra SHALL equal rc.
REQ-026 When a bus write and cen occur in the same cycle, the comparisons in that cycle SHALL use the old register value; the new value SHALL apply from the next cen.

Reset
REQ-027 On reset=1, the following SHALL be cleared, with state=NORMAL: R0–R15, the address register, hcc, vcc, rc, row_start, both width counters, hsync, vsync, dispen, ma and ra.
REQ-028 Reset asserted mid-frame SHALL take priority over cen and bus_we in the same cycle.

Structure
REQ-029 A shared package crtc_pkg SHALL hold:
- register index constants R_HTOTAL..R_CURLO;
- register width constants;
- the vertical state enum {V_NORMAL, V_ADJUST}.
REQ-030 The register file and bus decode SHALL be one sub-module, crtc_regfile; timing logic SHALL stay in crtc6845.

Verification
REQ-031 CPC defaults:
- Stimulus: cen every 16 ck16; R0=63, R1=40, R2=46, R3=0x8E, R4=38, R5=0, R6=25, R7=30, R9=7, R12=0x30, R13=0.
- Required response: 64-cen line; hsync high for 14 cen from hcc=46; dispen high for 40 cen on lines 0–199; frame of 312 lines; vsync high for 8 lines starting at line 240; ma=0x3000 at frame start and 0x3028 on line 8.
REQ-032 Vertical adjust: defaults with R5=4 -> frame of 316 lines; ra counts 0..3 in the last 4 lines; dispen=0 during those lines.
REQ-033 Zero widths: R3=0x00 -> hsync never asserts; vsync lasts 16 lines.
REQ-034 Register reads:
- Write R14=0xFF -> reads back 0x3F.
- Write R15=0xA5 -> reads back 0xA5.
- Read of R0 -> 0x00.
- Write with address 20 -> no register changes.
REQ-035 Reset mid-frame and cen gating:
- Reset asserted at line 100 -> all outputs 0 on the next ck16 edge.
- Holding cen=0 for 50 cycles -> hcc, ma and the sync outputs unchanged.
